// File: rtl/hazard_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// The master drives the ID/EX/MEM hazard inputs; the slave returns the enables, forwarding selects and counters.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_RS;
    logic [4:0]       ID_RT;
    logic             ID_UseRS;
    logic             ID_UseRT;
    logic             EX_RegWrite;
    logic             EX_MemRead;
    logic [4:0]       EX_WriteReg;
    logic             MEM_RegWrite;
    logic [4:0]       MEM_WriteReg;
    logic             branch_taken;
    logic             mem_stall;
    logic             PC_en;
    logic             IFID_en;
    logic             IFID_flush;
    logic             IDEX_bubble;
    logic             pipe_freeze;
    logic [1:0]       Ai;
    logic [1:0]       Bi;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_RS, ID_RT, ID_UseRS, ID_UseRT,
        output EX_RegWrite, EX_MemRead, EX_WriteReg,
        output MEM_RegWrite, MEM_WriteReg,
        output branch_taken, mem_stall,
        input  PC_en, IFID_en, IFID_flush, IDEX_bubble, pipe_freeze,
        input  Ai, Bi, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_RS, ID_RT, ID_UseRS, ID_UseRT,
        input  EX_RegWrite, EX_MemRead, EX_WriteReg,
        input  MEM_RegWrite, MEM_WriteReg,
        input  branch_taken, mem_stall,
        output PC_en, IFID_en, IFID_flush, IDEX_bubble, pipe_freeze,
        output Ai, Bi, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// EX-stage pipeline sequencer: registered forwarding selects, load-use bubbles,
// branch flushes and memory-stall freezes, plus saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz,
    output logic     fsm_lu
);
    typedef enum logic {RUN = 1'b0, LU = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state;
    logic   branch_pend;
    logic   branch_eff;
    logic   lu;

    // EX/MEM ALU result wins over MEM/WB; a load in EX cannot forward yet, and $0 never forwards.
    function automatic logic [1:0] fwd(input logic [4:0] r, input logic use_r);
        if (use_r && r != 5'd0 && hz.EX_RegWrite && !hz.EX_MemRead && hz.EX_WriteReg == r)
            return 2'b10;
        else if (use_r && r != 5'd0 && hz.MEM_RegWrite && hz.MEM_WriteReg == r)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // A branch seen while frozen is remembered so it still flushes once the freeze lifts.
    assign branch_eff = hz.branch_taken | branch_pend;

    assign lu = (state == RUN) && hz.EX_MemRead && (hz.EX_WriteReg != 5'd0) &&
                ((hz.ID_UseRS && hz.ID_RS == hz.EX_WriteReg) ||
                 (hz.ID_UseRT && hz.ID_RT == hz.EX_WriteReg));

    assign fsm_lu = (state == LU);

    // Enables are active-high "advance this cycle"; flush/bubble load NOPs; freeze holds the back end.
    always_comb begin
        hz.PC_en       = 1'b1;
        hz.IFID_en     = 1'b1;
        hz.IFID_flush  = 1'b0;
        hz.IDEX_bubble = 1'b0;
        hz.pipe_freeze = 1'b0;
        if (rst) begin
            hz.PC_en       = 1'b0;
            hz.IFID_en     = 1'b0;
            hz.IFID_flush  = 1'b1;
            hz.IDEX_bubble = 1'b1;
        end else if (hz.mem_stall) begin
            hz.PC_en       = 1'b0;
            hz.IFID_en     = 1'b0;
            hz.pipe_freeze = 1'b1;
        end else if (branch_eff) begin
            hz.IFID_flush  = 1'b1;
            hz.IDEX_bubble = 1'b1;
        end else if (lu) begin
            hz.PC_en       = 1'b0;
            hz.IFID_en     = 1'b0;
            hz.IDEX_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            branch_pend  <= 1'b0;
            hz.Ai        <= 2'b00;
            hz.Bi        <= 2'b00;
            hz.stall_cnt <= '0;
            hz.flush_cnt <= '0;
        end else if (hz.mem_stall) begin
            branch_pend <= branch_pend | hz.branch_taken;
            if (hz.stall_cnt != CNT_MAX)
                hz.stall_cnt <= hz.stall_cnt + 1'b1;
        end else if (branch_eff) begin
            state       <= RUN;
            branch_pend <= 1'b0;
            hz.Ai       <= 2'b00;
            hz.Bi       <= 2'b00;
            if (hz.flush_cnt != CNT_MAX)
                hz.flush_cnt <= hz.flush_cnt + 1'b1;
        end else if (lu) begin
            state       <= LU;
            branch_pend <= 1'b0;
            hz.Ai       <= 2'b00;
            hz.Bi       <= 2'b00;
            if (hz.stall_cnt != CNT_MAX)
                hz.stall_cnt <= hz.stall_cnt + 1'b1;
        end else begin
            state       <= RUN;
            branch_pend <= 1'b0;
            hz.Ai       <= fwd(hz.ID_RS, hz.ID_UseRS);
            hz.Bi       <= fwd(hz.ID_RT, hz.ID_UseRT);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush, freeze, saturation and reset.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    logic fsm_lu;
    int   errors = 0;
    int   checks = 0;

    hazard_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .hz     (hz),
        .fsm_lu (fsm_lu)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.ID_RS        = 5'd0;
        hz.ID_RT        = 5'd0;
        hz.ID_UseRS     = 1'b0;
        hz.ID_UseRT     = 1'b0;
        hz.EX_RegWrite  = 1'b0;
        hz.EX_MemRead   = 1'b0;
        hz.EX_WriteReg  = 5'd0;
        hz.MEM_RegWrite = 1'b0;
        hz.MEM_WriteReg = 5'd0;
        hz.branch_taken = 1'b0;
        hz.mem_stall    = 1'b0;
    endtask

    task automatic load_use_rt5();
        hz.EX_MemRead  = 1'b1;
        hz.EX_RegWrite = 1'b1;
        hz.EX_WriteReg = 5'd5;
        hz.ID_RT       = 5'd5;
        hz.ID_UseRT    = 1'b1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {11'd0, hz.PC_en, hz.IFID_en, hz.IFID_flush, hz.IDEX_bubble, hz.pipe_freeze},
              {11'd0, exp});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        // {PC_en, IFID_en, IFID_flush, IDEX_bubble, pipe_freeze}
        check_ctl("rst_ctl", 5'b00110);
        tick();
        tick();
        check("rst_ai", 16'(hz.Ai), 16'd0);
        check("rst_bi", 16'(hz.Bi), 16'd0);
        check("rst_stall", 16'(hz.stall_cnt), 16'd0);
        check("rst_flush", 16'(hz.flush_cnt), 16'd0);
        check("rst_fsm", 16'(fsm_lu), 16'd0);
        rst = 1'b0;

        // 1: EX forwarding of rs
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd3; hz.ID_RS = 5'd3; hz.ID_UseRS = 1'b1;
        #1;
        check_ctl("t1_ctl", 5'b11000);
        tick();
        check("t1_ai", 16'(hz.Ai), 16'd2);
        check("t1_stall", 16'(hz.stall_cnt), 16'd0);

        // 2: MEM-only, EX-over-MEM priority, $0 never forwarded, rt from MEM
        hz.EX_RegWrite = 1'b0; hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd3;
        tick();
        check("t2_mem_ai", 16'(hz.Ai), 16'd1);
        hz.EX_RegWrite = 1'b1;
        tick();
        check("t2_both_ai", 16'(hz.Ai), 16'd2);
        hz.ID_RS = 5'd0; hz.EX_WriteReg = 5'd0; hz.MEM_WriteReg = 5'd0;
        tick();
        check("t2_zero_ai", 16'(hz.Ai), 16'd0);
        idle();
        hz.ID_RT = 5'd7; hz.ID_UseRT = 1'b1; hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd7;
        tick();
        check("t2_mem_bi", 16'(hz.Bi), 16'd1);

        // 3: load-use bubble, then MEM forwarding of the load
        idle();
        load_use_rt5();
        #1;
        check_ctl("t3_lu_ctl", 5'b00010);
        tick();
        check("t3_bi", 16'(hz.Bi), 16'd0);
        check("t3_stall", 16'(hz.stall_cnt), 16'd1);
        check("t3_fsm_lu", 16'(fsm_lu), 16'd1);
        hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0; hz.EX_WriteReg = 5'd0;
        hz.MEM_RegWrite = 1'b1; hz.MEM_WriteReg = 5'd5;
        #1;
        check_ctl("t3_next_ctl", 5'b11000);
        tick();
        check("t3_next_bi", 16'(hz.Bi), 16'd1);
        check("t3_next_fsm", 16'(fsm_lu), 16'd0);
        check("t3_next_stall", 16'(hz.stall_cnt), 16'd1);

        // 3b: detector masked in LU even if the load still matches
        idle();
        load_use_rt5();
        tick();
        check("t3b_stall", 16'(hz.stall_cnt), 16'd2);
        #1;
        check_ctl("t3b_masked_ctl", 5'b11000);
        tick();
        check("t3b_fsm", 16'(fsm_lu), 16'd0);
        check("t3b_bi", 16'(hz.Bi), 16'd0);
        check("t3b_stall2", 16'(hz.stall_cnt), 16'd2);

        // 4: branch together with load-use
        load_use_rt5();
        hz.branch_taken = 1'b1;
        #1;
        check_ctl("t4_ctl", 5'b11110);
        tick();
        check("t4_flush", 16'(hz.flush_cnt), 16'd1);
        check("t4_stall", 16'(hz.stall_cnt), 16'd2);
        check("t4_fsm", 16'(fsm_lu), 16'd0);

        // 5: freeze with branch held, flush on the first free cycle
        idle();
        hz.EX_RegWrite = 1'b1; hz.EX_WriteReg = 5'd3; hz.ID_RS = 5'd3; hz.ID_UseRS = 1'b1;
        tick();
        check("t5_pre_ai", 16'(hz.Ai), 16'd2);
        hz.mem_stall = 1'b1; hz.branch_taken = 1'b1; hz.ID_RS = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctl("t5_freeze_ctl", 5'b00001);
            tick();
            check("t5_hold_ai", 16'(hz.Ai), 16'd2);
        end
        check("t5_stall", 16'(hz.stall_cnt), 16'd5);
        check("t5_noflush", 16'(hz.flush_cnt), 16'd1);
        hz.mem_stall = 1'b0;
        #1;
        check_ctl("t5_c4_ctl", 5'b11110);
        tick();
        check("t5_flush", 16'(hz.flush_cnt), 16'd2);
        check("t5_ai", 16'(hz.Ai), 16'd0);

        // 5b: branch seen only during the freeze still flushes afterwards
        idle();
        hz.mem_stall = 1'b1; hz.branch_taken = 1'b1;
        tick();
        idle();
        #1;
        check_ctl("t5b_ctl", 5'b11110);
        tick();
        check("t5b_flush", 16'(hz.flush_cnt), 16'd3);
        check("t5b_stall", 16'(hz.stall_cnt), 16'd6);

        // 6: saturation of the 4-bit stall counter
        hz.mem_stall = 1'b1;
        repeat (12) tick();
        check("t6_sat", 16'(hz.stall_cnt), 16'd15);
        idle();
        load_use_rt5();
        tick();
        check("t6_sat_lu", 16'(hz.stall_cnt), 16'd15);
        check("t6_in_lu", 16'(fsm_lu), 16'd1);

        // 6b: reset during LU
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_fsm", 16'(fsm_lu), 16'd0);
        check("t6_rst_ai", 16'(hz.Ai), 16'd0);
        check("t6_rst_bi", 16'(hz.Bi), 16'd0);
        check("t6_rst_stall", 16'(hz.stall_cnt), 16'd0);
        check("t6_rst_flush", 16'(hz.flush_cnt), 16'd0);

        // 6c: reset mid-freeze drops a pending branch
        idle();
        hz.mem_stall = 1'b1; hz.branch_taken = 1'b1;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_ctl("t6_nopend_ctl", 5'b11000);
        tick();
        check("t6_nopend_flush", 16'(hz.flush_cnt), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
